// File: rtl/parity_frame_tx.sv
// Serial transmitter for a 16-bit word framed as start, data LSB first, parity, stop.
// Define PARITY_FRAME_CHECK_EN to compile in a check of par_in against data_in.
module parity_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        par_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx_out,
    output logic        busy,
    output logic        par_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [15:0] LP_CNT_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [4:0]  r_bit_idx;
    logic [15:0] r_data;
    logic        r_par;
    logic        r_tx;
    logic        r_busy;
    logic        w_bit_done;

    assign w_bit_done = (r_cnt == LP_CNT_MAX);

    // NOTE: in_ready is decoded from state and gated by rst so it is low for the whole reset, including the first edge.
    assign in_ready = (r_state == ST_IDLE) && !rst;
    assign tx_out   = r_tx;
    assign busy     = r_busy;

    // NOTE: non-blocking assignments only; every register reads the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (in_valid) begin
                        r_data    <= data_in;
                        r_par     <= par_in;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (!w_bit_done) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_data[0];
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!w_bit_done) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else if (r_bit_idx == 5'd15) begin
                        r_cnt   <= '0;
                        r_tx    <= r_par;
                        r_state <= ST_PARITY;
                    end else begin
                        // Shift the word so the next data bit is always at index 1.
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 5'd1;
                        r_tx      <= r_data[1];
                        r_data    <= {1'b0, r_data[15:1]};
                    end
                end
                ST_PARITY: begin
                    if (!w_bit_done) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (!w_bit_done) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PARITY_FRAME_CHECK_EN
    logic r_par_err;

    // Pulses the cycle after an accept whose parity bit disagrees with the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= (r_state == ST_IDLE) && in_valid && (par_in != ^data_in);
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: instance 0 runs 4 clocks/bit, instance 1 runs 1 clock/bit,
// both checked every cycle against a frame-level model plus literal spot checks.
module tb_parity_frame_tx;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        par_in;
    logic        in_valid;
    logic [1:0]  rdy_w;
    logic [1:0]  tx_w;
    logic [1:0]  busy_w;
    logic [1:0]  perr_w;

    int tests;
    int fails;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        parity_frame_tx #(
            .CLKS_PER_BIT(g == 0 ? 4 : 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .data_in  (data_in),
            .par_in   (par_in),
            .in_valid (in_valid),
            .in_ready (rdy_w[g]),
            .tx_out   (tx_w[g]),
            .busy     (busy_w[g]),
            .par_err  (perr_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cpb_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Frame model: a 19-bit frame image and the number of cycles spent in it.
    bit          m_valid;
    bit          m_active [2];
    int          m_t      [2];
    logic [18:0] m_frame  [2];
    logic        m_perr   [2];

    always @(posedge clk) begin
        if (rst) m_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] = 1'b0;
                m_perr[i]   = 1'b0;
            end else begin
                m_perr[i] = 1'b0;
                if (m_active[i]) begin
                    m_t[i]++;
                    if (m_t[i] == 19 * cpb_of(i)) m_active[i] = 1'b0;
                end else if (in_valid) begin
                    m_active[i] = 1'b1;
                    m_t[i]      = 0;
                    m_frame[i]  = {1'b1, par_in, data_in, 1'b0};
`ifdef PARITY_FRAME_CHECK_EN
                    m_perr[i]   = par_in ^ (^data_in);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                logic exp_tx;
                exp_tx = m_active[i] ? m_frame[i][m_t[i] / cpb_of(i)] : 1'b1;
                check($sformatf("tx_out[%0d]", i), 32'(tx_w[i]), 32'(exp_tx));
                check($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_active[i]));
                check($sformatf("in_ready[%0d]", i), 32'(rdy_w[i]), 32'(!m_active[i] && !rst));
                check($sformatf("par_err[%0d]", i), 32'(perr_w[i]), 32'(m_perr[i]));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_w != 2'b00 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait_in_budget", 32'(n < 500), 32'd1);
    endtask

    task automatic send(input logic [15:0] d, input logic p);
        wait_idle();
        data_in  = d;
        par_in   = p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n_busy;
        int n_zero;
        int gap;
        int n_perr;
        int mism;
        bit ok;
        bit cap     [19];
        bit seq_exp [19];

        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        par_in   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(rdy_w), 32'd0);
        check("reset_tx_out", 32'(tx_w), 32'd3);
        check("reset_busy", 32'(busy_w), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(rdy_w), 32'd3);

        // All-zero word, 4 clocks/bit: 76 busy cycles, 72 of them low
        send(16'h0000, 1'b0);
        n_busy = 0;
        n_zero = 0;
        ok     = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy_w[0]) begin
                ok = 1'b1;
                break;
            end
            n_busy++;
            if (!tx_w[0]) n_zero++;
        end
        check("zero_frame_ended", 32'(ok), 32'd1);
        check("zero_frame_busy_cycles", 32'(n_busy), 32'd76);
        check("zero_frame_low_cycles", 32'(n_zero), 32'd72);

        // Edge bits set
        send(16'h8001, 1'b0);

        // in_valid held: second word only taken after an idle cycle
        wait_idle();
        data_in  = 16'h0003;
        par_in   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in = 16'h0007;
        par_in  = 1'b1;
        ok      = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy_w[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("held_valid_first_done", 32'(ok), 32'd1);
        gap = 1;
        while (!busy_w[0] && gap < 10) begin
            @(negedge clk);
            if (!busy_w[0]) gap++;
        end
        in_valid = 1'b0;
        check("held_valid_idle_gap", 32'(gap), 32'd1);

        // Reset 30 cycles into an all-ones frame
        send(16'hFFFF, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx_out", 32'(tx_w), 32'd3);
        check("abort_busy", 32'(busy_w), 32'd0);
        check("abort_in_ready", 32'(rdy_w), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(rdy_w), 32'd3);
        repeat (8) @(negedge clk);

        // Wrong parity is flagged (when built in) and still transmitted
        send(16'h0003, 1'b1);
        n_perr = (perr_w[0] === 1'b1) ? 1 : 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (perr_w[0] === 1'b1) n_perr++;
        end
`ifdef PARITY_FRAME_CHECK_EN
        check("par_err_pulses", 32'(n_perr), 32'd1);
`else
        check("par_err_pulses", 32'(n_perr), 32'd0);
`endif

        // One clock per bit, literal frame for 0xA5A5
        seq_exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        send(16'hA5A5, 1'b0);
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            cap[k] = tx_w[1];
        end
        mism = 0;
        for (int k = 0; k < 19; k++) begin
            if (cap[k] != seq_exp[k]) mism++;
        end
        check("a5a5_fast_frame_mismatches", 32'(mism), 32'd0);
        @(negedge clk);
        check("a5a5_fast_idle_after", 32'(busy_w[1]), 32'd0);

        wait_idle();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
